// File: rtl/imem_loader.sv
// Byte-stream program loader: 16-bit big-endian word count header, then big-endian 32-bit words.
// A write lands 1 cycle after a word's 4th byte; in_ready drops during writes, so upstream holds.
module imem_loader #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_WRITE, S_FINISH
  } state_t;

  localparam logic [16:0] LP_DEPTH = 17'(DEPTH);

  state_t      r_state;
  logic [7:0]  r_cnt_hi;
  logic [15:0] r_words;
  logic [1:0]  r_bcnt;
  logic [23:0] r_word;
  logic [31:0] r_addr;
  logic        r_in_ready;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_busy;
  logic        r_done;
  logic        r_error;

  logic        w_accept;
  logic [15:0] w_count;

  assign w_accept = in_valid && r_in_ready;
  assign w_count  = {r_cnt_hi, in_data};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt_hi    <= 8'd0;
      r_words     <= 16'd0;
      r_bcnt      <= 2'd0;
      r_word      <= 24'd0;
      r_addr      <= 32'd0;
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_HDR_HI;
            r_busy     <= 1'b1;
            r_error    <= 1'b0;
            r_addr     <= BASE_ADDR;
            r_bcnt     <= 2'd0;
            r_in_ready <= 1'b1;
          end
        end
        S_HDR_HI: begin
          if (w_accept) begin
            r_cnt_hi <= in_data;
            r_state  <= S_HDR_LO;
          end
        end
        S_HDR_LO: begin
          if (w_accept) begin
            if ({1'b0, w_count} > LP_DEPTH) begin
              r_error    <= 1'b1;
              r_busy     <= 1'b0;
              r_in_ready <= 1'b0;
              r_state    <= S_IDLE;
            end else if (w_count == 16'd0) begin
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_in_ready <= 1'b0;
              r_state    <= S_FINISH;
            end else begin
              r_words <= w_count;
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_word <= {r_word[15:0], in_data};
            r_bcnt <= r_bcnt + 2'd1;
            // Fourth byte completes the word; capture it straight into the write port.
            if (r_bcnt == 2'd3) begin
              r_mem_wdata <= {r_word, in_data};
              r_mem_addr  <= r_addr;
              r_mem_we    <= 1'b1;
              r_in_ready  <= 1'b0;
              r_state     <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          r_addr  <= r_addr + 32'd4;
          r_words <= r_words - 16'd1;
          if (r_words == 16'd1) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_in_ready <= 1'b1;
            r_state    <= S_DATA;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 0x0 and 0x40) share one stimulus stream and one event model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;

  logic        rdy0, we0, busy0, done0, err0;
  logic [31:0] addr0, wd0;
  logic        rdy1, we1, busy1, done1, err1;
  logic [31:0] addr1, wd1;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(256), .BASE_ADDR(32'h0000_0000)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
    .busy(busy0), .done(done0), .error(err0)
  );

  imem_loader #(.DEPTH(256), .BASE_ADDR(32'h0000_0040)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
    .busy(busy1), .done(done1), .error(err1)
  );

  typedef struct {
    logic [31:0] off;
    logic [31:0] dat;
    int          due;
  } wr_t;

  int          total = 0;
  int          bad   = 0;
  int          ncyc  = 0;
  wr_t         wq[$];
  int          dq[$];
  logic [31:0] prog [0:3];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, ncyc);
    end
  endtask

  // Event model: every write and done pulse is predicted by the stimulus from the program contents.
  always @(negedge clk) begin
    wr_t w;
    ncyc++;
    if (we0 || we1) begin
      if (wq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: we0=%b we1=%b addr0=%h (cycle %0d)", we0, we1, addr0, ncyc);
      end else begin
        w = wq.pop_front();
        check("we0", 32'(we0), 32'd1);
        check("we1", 32'(we1), 32'd1);
        check("write_cycle", 32'(ncyc), 32'(w.due));
        check("addr0", addr0, w.off);
        check("addr1", addr1, 32'h40 + w.off);
        check("addr1_align", 32'(addr1[1:0]), 32'd0);
        check("wdata0", wd0, w.dat);
        check("wdata1", wd1, w.dat);
        check("ready_low_in_write", 32'({rdy0, rdy1}), 32'd0);
        check("busy_in_write", 32'({busy0, busy1}), 32'd3);
      end
    end
    if (done0 || done1) begin
      if (dq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: done0=%b done1=%b (cycle %0d)", done0, done1, ncyc);
      end else begin
        check("done_cycle", 32'(ncyc), 32'(dq.pop_front()));
        check("done_both", 32'({done0, done1}), 32'd3);
        check("busy_low_at_done", 32'({busy0, busy1}), 32'd0);
        check("no_error_at_done", 32'({err0, err1}), 32'd0);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = rdy0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL byte_timeout: byte %h never accepted (cycle %0d)", b, ncyc);
    end
  endtask

  task automatic load(input int cnt, input int gap);
    pulse_start();
    send_byte(8'(cnt >> 8), gap);
    send_byte(8'(cnt), gap);
    if (cnt == 0) dq.push_back(ncyc + 1);
    for (int i = 0; i < cnt; i++) begin
      for (int b = 0; b < 4; b++) begin
        send_byte(prog[i][31 - 8*b -: 8], gap);
      end
      wq.push_back('{off: 32'(4 * i), dat: prog[i], due: ncyc + 1});
      if (i == cnt - 1) dq.push_back(ncyc + 2);
    end
    repeat (4) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_ctl0"}, 32'({rdy0, we0, busy0, done0, err0}), 32'd0);
    check({nm, "_ctl1"}, 32'({rdy1, we1, busy1, done1, err1}), 32'd0);
    check({nm, "_addr"}, addr0 | addr1, 32'd0);
    check({nm, "_wdata"}, wd0 | wd1, 32'd0);
  endtask

  initial begin
    prog[0] = 32'h8C09_0000;
    prog[1] = 32'h212B_0005;
    prog[2] = 32'hAC0B_0008;
    prog[3] = 32'h0000_0000;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Three-word program, back-to-back bytes.
    load(3, 0);
    check("t1_queues_empty", 32'(wq.size() + dq.size()), 32'd0);
    check("t1_last_wdata", wd0, 32'hAC0B_0008);
    check("t1_last_addr0", addr0, 32'h0000_0008);
    check("t1_last_addr1", addr1, 32'h0000_0048);
    check("t1_idle", 32'({busy0, rdy0, err0}), 32'd0);

    // Same program with in_valid toggling every cycle.
    load(3, 1);
    check("t2_queues_empty", 32'(wq.size() + dq.size()), 32'd0);

    // Empty program.
    load(0, 0);
    check("t3_queues_empty", 32'(dq.size()), 32'd0);
    check("t3_no_error", 32'({err0, err1}), 32'd0);

    // Oversize header: 257 words.
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    check("t4_error_set", 32'({err0, err1}), 32'd3);
    check("t4_busy_low", 32'({busy0, busy1}), 32'd0);
    check("t4_ready_low", 32'({rdy0, rdy1}), 32'd0);
    repeat (3) @(negedge clk);
    check("t4_error_sticky", 32'(err0), 32'd1);
    @(posedge clk); #1;
    prog[0] = 32'hDEAD_BEEF;
    load(1, 0);
    check("t4_error_cleared", 32'({err0, err1}), 32'd0);
    check("t4_queues_empty", 32'(wq.size() + dq.size()), 32'd0);
    check("t4_wdata", wd0, 32'hDEAD_BEEF);

    // Start during DATA is ignored; reset mid-word discards the partial bytes.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    pulse_start();
    check("t5_busy_after_start", 32'({busy0, busy1}), 32'd3);
    check("t5_ready_after_start", 32'({rdy0, rdy1}), 32'd3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_all_zero("t5_reset");
    prog[0] = 32'h5566_7788;
    load(1, 0);
    check("t5_queues_empty", 32'(wq.size() + dq.size()), 32'd0);
    check("t5_wdata", wd0, 32'h5566_7788);
    check("t5_addr0", addr0, 32'h0000_0000);

    // Two-word program: base-0x40 instance writes at 0x40 and 0x44.
    prog[0] = 32'h0123_4567;
    prog[1] = 32'h89AB_CDEF;
    load(2, 0);
    check("t6_queues_empty", 32'(wq.size() + dq.size()), 32'd0);
    check("t6_addr1", addr1, 32'h0000_0044);
    check("t6_wdata1", wd1, 32'h89AB_CDEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
